piezo_alert_scheduler: RTL and testbench
========================================

Name: piezo_alert_scheduler

Overview:
- Owns the single piezo output and shares it between five requesters, each with its own tone and duration.
- Requesters: keypad click, periodic timer beep, event-1 overload warning, bomb-defused jingle, explosion jingle.
- Applies a fixed priority and latches terminal jingles; it generates the square-wave tone itself.
- Replaces the direct OR of warning and beep signals in game_top; its output drives piezo_out.

Parameters:
- CLICK_TICKS, 1_000_000, click duration in clk cycles (20 ms).
- BEEP_TICKS, 25_000_000, timer beep duration in clk cycles (0.5 s).
- NOTE_TICKS, 6_250_000, length of each jingle note in clk cycles (125 ms).
- Tone half-periods are fixed localparams, in 18-bit clk counts: CLICK 6250 (4 kHz), BEEP 25000 (1 kHz), WARN 12500 (2 kHz).
- Clear jingle: 47801, 37936, 31888, 23878.
- Over jingle: 63776, 75758, 95420, 190840.

Ports:
- clk  in  1  50 MHz system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- enable  in  1  0 = mute: output low, state IDLE, pending flags cleared.
- click_req  in  1  one-cycle pulse, key press.
- beep_req  in  1  one-cycle pulse, timer beep.
- warn_level  in  1  level, overload warning active.
- clear_req  in  1  one-cycle pulse, game cleared.
- over_req  in  1  one-cycle pulse, game over.
- piezo_out  out  1  square-wave drive.
- busy  out  1  state != IDLE.
- active_src  out  3  0 IDLE, 1 CLICK, 2 BEEP, 3 WARN, 4 CLEAR, 5 OVER.

Behaviour:
- Reset: state IDLE; piezo_out=0, busy=0, active_src=0; all counters 0; clear_pend=over_pend=0.
- Priority, highest first: OVER > CLEAR > WARN > BEEP > CLICK.
- States: IDLE, CLICK, BEEP, WARN, CLEAR, OVER. All outputs are registered.
- A request sampled at edge N takes effect at edge N+1. The new state and the first high half-cycle of the tone are visible after edge N+1.
- State entry: dur_cnt=0, tone_cnt=0, tone=1, note_idx=0.
- Tone generation: tone_cnt increments every cycle while active. At half_period-1, tone toggles and tone_cnt returns to 0.
- piezo_out = tone when active, 0 in IDLE.
- CLICK / BEEP: dur_cnt counts to CLICK_TICKS-1 / BEEP_TICKS-1, then the state goes to IDLE, or straight to a pending jingle.
- Accept rules:
  - click_req is accepted only in IDLE.
  - beep_req is accepted in IDLE or CLICK; in CLICK the click is preempted and discarded.
  - Requests that are not accepted are dropped; there is no latch for click or beep.
- WARN: entered from IDLE, CLICK or BEEP while warn_level=1; the preempted beep or click is discarded.
  - WARN has no duration; it exits to IDLE the cycle after warn_level falls.
  - A beep or click arriving during WARN is dropped.
- CLEAR / OVER:
  - Entered from any lower state on the request, preempting it.
  - 4 notes of NOTE_TICKS each. On each note boundary note_idx increments, the half-period reloads, and tone_cnt=0 with tone=1.
  - After note 3 the state goes to IDLE, or to the other jingle if its pending flag is set, or to WARN if warn_level=1.
  - Jingles are never preempted. clear_req during OVER sets clear_pend; over_req during CLEAR sets over_pend.
  - Entering a jingle clears its own pending flag.
- Simultaneous requests in one cycle: highest priority wins.
  - clear_req together with over_req: OVER plays and clear_req is discarded (not latched).
- A repeat request for the currently playing jingle is ignored.
- enable=0 overrides everything within one cycle: state IDLE, pending flags cleared, outputs low.
  - Requests are ignored while enable=0.
  - warn_level still high when enable returns to 1 re-enters WARN one cycle later.
- sys_rst mid-operation: immediate return to reset values, no partial note completes.

Test Plan:
- Override CLICK_TICKS=100. click_req at t0 -> active_src=1 from t0+1. piezo_out toggles every 6250 cycles, so it stays high for all 100 cycles; IDLE after cycle t0+101.
- Override CLICK_TICKS=100000. click_req, then beep_req 50 cycles later -> active_src 1->2. BEEP runs the full BEEP_TICKS and piezo_out period is 50000 cycles.
- warn_level=1 during BEEP -> WARN next cycle with half-period 12500. A beep_req during WARN is ignored. warn_level=0 -> IDLE the following cycle.
- Override NOTE_TICKS=200000. clear_req, then over_req at note 1 -> CLEAR plays its 4 notes with half-periods 47801/37936/31888/23878. OVER starts at the cycle after note 3 ends, then IDLE.
- clear_req and over_req in the same cycle -> OVER only; clear not replayed afterwards and busy falls after 4*NOTE_TICKS.
- During OVER with over_pend and clear_pend cases set, drop enable to 0 -> next cycle piezo_out=0, active_src=0, pend=0. Re-raise enable with no requests -> stays IDLE. Assert sys_rst mid-note -> outputs 0 immediately.

Source files
------------

// File: rtl/piezo_alert_scheduler.sv
// rtl/piezo_alert_scheduler.sv - Prioritised piezo tone scheduler for five alert sources
//
// Purpose: owns the single piezo output and arbitrates between keypad click,
// timer beep, overload warning, and the two terminal jingles (clear / over).
// It generates the square-wave tone internally; all outputs are registered.
//
// Ports:
//   clk        in   50 MHz system clock
//   sys_rst    in   asynchronous active-high reset
//   enable     in   0 = mute (IDLE, pending flags cleared, outputs low)
//   click_req  in   one-cycle key press pulse
//   beep_req   in   one-cycle timer beep pulse
//   warn_level in   overload warning level
//   clear_req  in   one-cycle game-cleared pulse
//   over_req   in   one-cycle game-over pulse
//   piezo_out  out  square-wave drive
//   busy       out  state != IDLE
//   active_src out  0 IDLE, 1 CLICK, 2 BEEP, 3 WARN, 4 CLEAR, 5 OVER
module piezo_alert_scheduler #(
  parameter int unsigned CLICK_TICKS = 1_000_000,
  parameter int unsigned BEEP_TICKS  = 25_000_000,
  parameter int unsigned NOTE_TICKS  = 6_250_000
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       enable,
  input  logic       click_req,
  input  logic       beep_req,
  input  logic       warn_level,
  input  logic       clear_req,
  input  logic       over_req,
  output logic       piezo_out,
  output logic       busy,
  output logic [2:0] active_src
);

  // State encoding doubles as the active_src code.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLICK = 3'd1;
  localparam logic [2:0] S_BEEP  = 3'd2;
  localparam logic [2:0] S_WARN  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  // Tone half-periods in clk cycles.
  localparam logic [17:0] HP_CLICK = 18'd6250;
  localparam logic [17:0] HP_BEEP  = 18'd25000;
  localparam logic [17:0] HP_WARN  = 18'd12500;
  localparam logic [17:0] HP_CLR0  = 18'd47801;
  localparam logic [17:0] HP_CLR1  = 18'd37936;
  localparam logic [17:0] HP_CLR2  = 18'd31888;
  localparam logic [17:0] HP_CLR3  = 18'd23878;
  localparam logic [17:0] HP_OVR0  = 18'd63776;
  localparam logic [17:0] HP_OVR1  = 18'd75758;
  localparam logic [17:0] HP_OVR2  = 18'd95420;
  localparam logic [17:0] HP_OVR3  = 18'd190840;

  localparam logic [31:0] CLICK_LAST = 32'(CLICK_TICKS - 1);
  localparam logic [31:0] BEEP_LAST  = 32'(BEEP_TICKS - 1);
  localparam logic [31:0] NOTE_LAST  = 32'(NOTE_TICKS - 1);

  logic [2:0]  state_q,      state_d;
  logic [31:0] dur_cnt_q,    dur_cnt_d;
  logic [17:0] tone_cnt_q,   tone_cnt_d;
  logic        tone_q,       tone_d;
  logic [1:0]  note_idx_q,   note_idx_d;
  logic        clear_pend_q, clear_pend_d;
  logic        over_pend_q,  over_pend_d;
  logic        piezo_q,      piezo_d;
  logic        busy_q,       busy_d;
  logic [2:0]  src_q,        src_d;

  logic [17:0] half_period;
  logic        dur_last;
  logic        restart;
  logic        note_step;

  // Half-period for the tone currently playing.
  always_comb begin
    half_period = HP_CLICK;
    case (state_q)
      S_CLICK: half_period = HP_CLICK;
      S_BEEP:  half_period = HP_BEEP;
      S_WARN:  half_period = HP_WARN;
      S_CLEAR: begin
        case (note_idx_q)
          2'd0:    half_period = HP_CLR0;
          2'd1:    half_period = HP_CLR1;
          2'd2:    half_period = HP_CLR2;
          default: half_period = HP_CLR3;
        endcase
      end
      S_OVER: begin
        case (note_idx_q)
          2'd0:    half_period = HP_OVR0;
          2'd1:    half_period = HP_OVR1;
          2'd2:    half_period = HP_OVR2;
          default: half_period = HP_OVR3;
        endcase
      end
      default: half_period = HP_CLICK;
    endcase
  end

  // Last cycle of the current duration window (click, beep, or jingle note).
  always_comb begin
    dur_last = 1'b0;
    case (state_q)
      S_CLICK:         dur_last = (dur_cnt_q == CLICK_LAST);
      S_BEEP:          dur_last = (dur_cnt_q == BEEP_LAST);
      S_CLEAR, S_OVER: dur_last = (dur_cnt_q == NOTE_LAST);
      default:         dur_last = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      dur_cnt_q    <= '0;
      tone_cnt_q   <= '0;
      tone_q       <= 1'b0;
      note_idx_q   <= '0;
      clear_pend_q <= 1'b0;
      over_pend_q  <= 1'b0;
      piezo_q      <= 1'b0;
      busy_q       <= 1'b0;
      src_q        <= S_IDLE;
    end else begin
      state_q      <= state_d;
      dur_cnt_q    <= dur_cnt_d;
      tone_cnt_q   <= tone_cnt_d;
      tone_q       <= tone_d;
      note_idx_q   <= note_idx_d;
      clear_pend_q <= clear_pend_d;
      over_pend_q  <= over_pend_d;
      piezo_q      <= piezo_d;
      busy_q       <= busy_d;
      src_q        <= src_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    clear_pend_d = clear_pend_q;
    over_pend_d  = over_pend_q;
    note_step    = 1'b0;

    if (!enable) begin
      state_d      = S_IDLE;
      clear_pend_d = 1'b0;
      over_pend_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (over_req)        state_d = S_OVER;
          else if (clear_req)  state_d = S_CLEAR;
          else if (warn_level) state_d = S_WARN;
          else if (beep_req)   state_d = S_BEEP;
          else if (click_req)  state_d = S_CLICK;
        end
        S_CLICK, S_BEEP: begin
          if (over_req)                          state_d = S_OVER;
          else if (clear_req)                    state_d = S_CLEAR;
          else if (warn_level)                   state_d = S_WARN;
          else if (state_q == S_CLICK && beep_req) state_d = S_BEEP;
          else if (dur_last) begin
            if (over_pend_q)       state_d = S_OVER;
            else if (clear_pend_q) state_d = S_CLEAR;
            else                   state_d = S_IDLE;
          end
        end
        S_WARN: begin
          if (over_req)         state_d = S_OVER;
          else if (clear_req)   state_d = S_CLEAR;
          else if (!warn_level) state_d = S_IDLE;
        end
        S_CLEAR: begin
          if (over_req) over_pend_d = 1'b1;
          if (dur_last) begin
            if (note_idx_q != 2'd3)         note_step = 1'b1;
            else if (over_pend_q || over_req) state_d = S_OVER;
            else if (warn_level)            state_d = S_WARN;
            else                            state_d = S_IDLE;
          end
        end
        S_OVER: begin
          if (clear_req) clear_pend_d = 1'b1;
          if (dur_last) begin
            if (note_idx_q != 2'd3)            note_step = 1'b1;
            else if (clear_pend_q || clear_req) state_d = S_CLEAR;
            else if (warn_level)               state_d = S_WARN;
            else                               state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // No state ever re-enters itself, so any change of state is an entry.
    restart = (state_d != state_q);

    if (restart && state_d == S_CLEAR) clear_pend_d = 1'b0;
    if (restart && state_d == S_OVER)  over_pend_d  = 1'b0;

    if (state_d == S_IDLE) begin
      dur_cnt_d  = '0;
      tone_cnt_d = '0;
      tone_d     = 1'b0;
      note_idx_d = '0;
    end else if (restart || note_step) begin
      dur_cnt_d  = '0;
      tone_cnt_d = '0;
      tone_d     = 1'b1;
      note_idx_d = restart ? 2'd0 : note_idx_q + 2'd1;
    end else begin
      // WARN has no duration, so its counter stays parked at zero.
      dur_cnt_d  = (state_q == S_WARN) ? 32'd0 : dur_cnt_q + 32'd1;
      note_idx_d = note_idx_q;
      if (tone_cnt_q == half_period - 18'd1) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 18'd1;
        tone_d     = tone_q;
      end
    end
  end

  // Output logic: computed from next-state values so the registered outputs
  // line up with the state they describe.
  always_comb begin
    piezo_d = (state_d != S_IDLE) && tone_d;
    busy_d  = (state_d != S_IDLE);
    src_d   = state_d;
  end

  assign piezo_out  = piezo_q;
  assign busy       = busy_q;
  assign active_src = src_q;

endmodule

// File: tb/tb_piezo_alert_scheduler.sv
// tb/tb_piezo_alert_scheduler.sv - Directed self-checking bench for piezo_alert_scheduler
module tb_piezo_alert_scheduler;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       enable;
  logic       click_req;
  logic       beep_req;
  logic       warn_level;
  logic       clear_req;
  logic       over_req;
  logic       piezo_out;
  logic       busy;
  logic [2:0] active_src;

  int checks = 0;
  int errors = 0;

  piezo_alert_scheduler #(
    .CLICK_TICKS(7000),
    .BEEP_TICKS (50),
    .NOTE_TICKS (15)
  ) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .enable    (enable),
    .click_req (click_req),
    .beep_req  (beep_req),
    .warn_level(warn_level),
    .clear_req (clear_req),
    .over_req  (over_req),
    .piezo_out (piezo_out),
    .busy      (busy),
    .active_src(active_src)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    sys_rst = 1'b1; enable = 1'b1;
    click_req = 1'b0; beep_req = 1'b0; warn_level = 1'b0;
    clear_req = 1'b0; over_req = 1'b0;
    step(2);
    chk("rst_src", 32'(active_src), 0);
    chk("rst_piezo", 32'(piezo_out), 0);
    chk("rst_busy", 32'(busy), 0);
    sys_rst = 1'b0;
    step(1);
    chk("idle_src", 32'(active_src), 0);

    // Click: 4 kHz tone toggles after 6250 cycles, click lasts 7000 cycles.
    click_req = 1'b1; step(1); click_req = 1'b0;
    chk("click_src", 32'(active_src), 1);
    chk("click_piezo", 32'(piezo_out), 1);
    chk("click_busy", 32'(busy), 1);
    step(6249);
    chk("click_hi_6249", 32'(piezo_out), 1);
    step(1);
    chk("click_lo_6250", 32'(piezo_out), 0);
    step(749);
    chk("click_last", 32'(active_src), 1);
    step(1);
    chk("click_end_src", 32'(active_src), 0);
    chk("click_end_busy", 32'(busy), 0);
    chk("click_end_piezo", 32'(piezo_out), 0);

    // Beep preempts click; beep lasts 50 cycles.
    click_req = 1'b1; step(1); click_req = 1'b0;
    step(49);
    beep_req = 1'b1; step(1); beep_req = 1'b0;
    chk("beep_preempt", 32'(active_src), 2);
    chk("beep_piezo", 32'(piezo_out), 1);
    step(49);
    chk("beep_last", 32'(active_src), 2);
    step(1);
    chk("beep_end", 32'(active_src), 0);

    // Warn preempts beep; beep during warn dropped; 2 kHz toggles at 12500.
    beep_req = 1'b1; step(1); beep_req = 1'b0;
    chk("beep2_src", 32'(active_src), 2);
    warn_level = 1'b1; step(1);
    chk("warn_src", 32'(active_src), 3);
    beep_req = 1'b1; step(1); beep_req = 1'b0;
    chk("warn_beep_drop", 32'(active_src), 3);
    step(12498);
    chk("warn_hi_12499", 32'(piezo_out), 1);
    step(1);
    chk("warn_lo_12500", 32'(piezo_out), 0);
    warn_level = 1'b0; step(1);
    chk("warn_exit", 32'(active_src), 0);

    // Clear jingle, over requested during note 1, over follows after note 3.
    clear_req = 1'b1; step(1); clear_req = 1'b0;
    chk("clear_src", 32'(active_src), 4);
    step(19);
    over_req = 1'b1; clear_req = 1'b1; step(1); over_req = 1'b0; clear_req = 1'b0;
    chk("clear_no_preempt", 32'(active_src), 4);
    step(39);
    chk("clear_last", 32'(active_src), 4);
    step(1);
    chk("over_after_clear", 32'(active_src), 5);
    chk("over_piezo", 32'(piezo_out), 1);
    step(59);
    chk("over_last", 32'(active_src), 5);
    step(1);
    chk("jingles_done_src", 32'(active_src), 0);
    chk("jingles_done_busy", 32'(busy), 0);

    // Simultaneous clear+over: over only, clear discarded.
    clear_req = 1'b1; over_req = 1'b1; step(1); clear_req = 1'b0; over_req = 1'b0;
    chk("simul_src", 32'(active_src), 5);
    step(59);
    chk("simul_last", 32'(active_src), 5);
    step(1);
    chk("simul_end_busy", 32'(busy), 0);
    step(5);
    chk("simul_no_clear", 32'(active_src), 0);

    // Mute during over with clear pending.
    over_req = 1'b1; step(1); over_req = 1'b0;
    clear_req = 1'b1; step(1); clear_req = 1'b0;
    chk("pend_over_src", 32'(active_src), 5);
    enable = 1'b0; step(1);
    chk("mute_src", 32'(active_src), 0);
    chk("mute_piezo", 32'(piezo_out), 0);
    chk("mute_busy", 32'(busy), 0);
    click_req = 1'b1; step(1); click_req = 1'b0;
    chk("mute_click_ign", 32'(active_src), 0);
    enable = 1'b1; step(3);
    chk("unmute_idle", 32'(active_src), 0);
    over_req = 1'b1; step(1); over_req = 1'b0;
    step(59);
    chk("over2_last", 32'(active_src), 5);
    step(1);
    chk("pend_cleared", 32'(active_src), 0);

    // Warn held through mute re-enters on enable; over preempts warn and returns to it.
    enable = 1'b0; warn_level = 1'b1; step(2);
    chk("mute_warn", 32'(active_src), 0);
    enable = 1'b1; step(1);
    chk("warn_reenter", 32'(active_src), 3);
    over_req = 1'b1; step(1); over_req = 1'b0;
    chk("over_preempt_warn", 32'(active_src), 5);
    step(60);
    chk("over_to_warn", 32'(active_src), 3);
    warn_level = 1'b0; step(1);
    chk("warn_exit2", 32'(active_src), 0);

    // Priority among simultaneous short requests, then async reset mid-note.
    click_req = 1'b1; beep_req = 1'b1; step(1); click_req = 1'b0; beep_req = 1'b0;
    chk("prio_beep", 32'(active_src), 2);
    clear_req = 1'b1; step(1); clear_req = 1'b0;
    chk("clear_preempt_beep", 32'(active_src), 4);
    step(5);
    sys_rst = 1'b1; #1;
    chk("async_rst_src", 32'(active_src), 0);
    chk("async_rst_piezo", 32'(piezo_out), 0);
    chk("async_rst_busy", 32'(busy), 0);
    step(1);
    sys_rst = 1'b0; step(2);
    chk("post_rst_idle", 32'(active_src), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
